// File: rtl/quarter_sine_nco_ctrl.sv
// rtl/quarter_sine_nco_ctrl.sv - phase accumulator and I/Q sequencer sharing one quarter-wave sine LUT
module quarter_sine_nco_ctrl #(
    parameter int PHASE_BITS = 32,
    parameter int ADDR_BITS  = 8,
    parameter int FRAC_BITS  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [PHASE_BITS-1:0]   phase_inc_i,
    input  logic                    phase_load_i,
    input  logic [PHASE_BITS-1:0]   phase_i,
    output logic [ADDR_BITS-1:0]    lut_addr_o,
    input  logic [FRAC_BITS:0]      lut_sample_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [FRAC_BITS+1:0]    sin_o,
    output logic [FRAC_BITS+1:0]    cos_o
);

    localparam int OUT_BITS = FRAC_BITS + 2;
    localparam int TOP_BITS = ADDR_BITS + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_S = 2'd1,
        ISSUE_C = 2'd2,
        CAPT_C  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [PHASE_BITS-1:0]       acc_q, acc_d;
    logic [TOP_BITS-1:0]         cur_phase_q, cur_phase_d;
    logic [ADDR_BITS-1:0]        addr_q, addr_d;
    logic signed [OUT_BITS-1:0]  sin_tmp_q, sin_tmp_d;
    logic signed [OUT_BITS-1:0]  sin_q, sin_d;
    logic signed [OUT_BITS-1:0]  cos_q, cos_d;
    logic                        valid_q, valid_d;

    logic [PHASE_BITS-1:0]       start_phase;
    logic [1:0]                  start_quad, cur_quad, cos_quad;
    logic [ADDR_BITS-1:0]        start_idx, cur_idx;

    // Odd quadrants read the table mirrored; N-idx wraps to 0 for idx=0, which is the bypass case.
    function automatic logic [ADDR_BITS-1:0] fold_addr(input logic [1:0] qq,
                                                       input logic [ADDR_BITS-1:0] idx);
        return qq[0] ? ({ADDR_BITS{1'b0}} - idx) : idx;
    endfunction

    function automatic logic is_bypass(input logic [1:0] qq, input logic [ADDR_BITS-1:0] idx);
        return qq[0] && (idx == '0);
    endfunction

    function automatic logic signed [OUT_BITS-1:0] restore(input logic [1:0] qq,
                                                          input logic [ADDR_BITS-1:0] idx,
                                                          input logic [FRAC_BITS:0] sample);
        logic [OUT_BITS-1:0] mag;
        if (is_bypass(qq, idx)) begin
            mag = '0;
            mag[FRAC_BITS] = 1'b1;
        end else begin
            mag = {1'b0, sample};
        end
        return qq[1] ? -mag : mag;
    endfunction

    assign start_phase = phase_load_i ? phase_i : acc_q;
    assign start_quad  = start_phase[PHASE_BITS-1 -: 2];
    assign start_idx   = start_phase[PHASE_BITS-3 -: ADDR_BITS];
    assign cur_quad    = cur_phase_q[TOP_BITS-1 -: 2];
    assign cur_idx     = cur_phase_q[ADDR_BITS-1:0];
    assign cos_quad    = cur_quad + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cur_phase_q <= '0;
            addr_q      <= '0;
            sin_tmp_q   <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cur_phase_q <= cur_phase_d;
            addr_q      <= addr_d;
            sin_tmp_q   <= sin_tmp_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ISSUE_S;
            ISSUE_S: state_d = ISSUE_C;
            ISSUE_C: state_d = CAPT_C;
            CAPT_C:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The address register is loaded one transition early so each read address is
    // on lut_addr_o for the whole issue cycle; bypassed channels leave it untouched.
    always_comb begin
        acc_d       = acc_q;
        cur_phase_d = cur_phase_q;
        addr_d      = addr_q;
        sin_tmp_d   = sin_tmp_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        valid_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_phase_d = start_phase[PHASE_BITS-1 -: TOP_BITS];
                    acc_d       = start_phase + phase_inc_i;
                    if (!is_bypass(start_quad, start_idx)) begin
                        addr_d = fold_addr(start_quad, start_idx);
                    end
                end else if (phase_load_i) begin
                    acc_d = phase_i;
                end
            end
            ISSUE_S: begin
                if (!is_bypass(cos_quad, cur_idx)) begin
                    addr_d = fold_addr(cos_quad, cur_idx);
                end
            end
            ISSUE_C: begin
                sin_tmp_d = restore(cur_quad, cur_idx, lut_sample_i);
            end
            CAPT_C: begin
                sin_d   = sin_tmp_q;
                cos_d   = restore(cos_quad, cur_idx, lut_sample_i);
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign lut_addr_o = addr_q;
    assign busy_o     = (state_q != IDLE);
    assign valid_o    = valid_q;
    assign sin_o      = sin_q;
    assign cos_o      = cos_q;

endmodule

// File: tb/tb_quarter_sine_nco_ctrl.sv
// tb/tb_quarter_sine_nco_ctrl.sv - directed bench for quarter_sine_nco_ctrl with a registered LUT model
module tb_quarter_sine_nco_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] phase_inc_i;
    logic       phase_load_i;
    logic [7:0] phase_i;
    logic [3:0] lut_addr_o;
    logic [8:0] lut_sample_i;
    logic       busy_o;
    logic       valid_o;
    logic [9:0] sin_o;
    logic [9:0] cos_o;

    int errors = 0;
    int checks = 0;

    logic [8:0] rom [16];

    always #5 clk = ~clk;

    always @(posedge clk) lut_sample_i <= rom[lut_addr_o];

    quarter_sine_nco_ctrl #(
        .PHASE_BITS(8),
        .ADDR_BITS (4),
        .FRAC_BITS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .phase_inc_i (phase_inc_i),
        .phase_load_i(phase_load_i),
        .phase_i     (phase_i),
        .lut_addr_o  (lut_addr_o),
        .lut_sample_i(lut_sample_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .sin_o       (sin_o),
        .cos_o       (cos_o)
    );

    // Drives one start in cycle A and observes A+1..A+8 at falling edges.
    task automatic do_pair(input logic load, input logic [7:0] ph, input logic [7:0] inc,
                           input logic busy_load,
                           output logic [3:0] a_s, output logic [3:0] a_c,
                           output logic [3:0] busy_bits, output int lat,
                           output logic [9:0] s, output logic [9:0] c);
        lat = 0; s = 'x; c = 'x; busy_bits = '0;
        @(negedge clk);
        start_i = 1'b1; phase_load_i = load; phase_i = ph; phase_inc_i = inc;
        @(negedge clk);
        start_i = 1'b0; phase_load_i = 1'b0;
        a_s = lut_addr_o; busy_bits[0] = busy_o;
        @(negedge clk);
        a_c = lut_addr_o; busy_bits[1] = busy_o;
        if (busy_load) begin
            phase_load_i = 1'b1; phase_i = 8'h80;
        end
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            phase_load_i = 1'b0;
            if (k <= 4) busy_bits[k-1] = busy_o;
            if (valid_o && lat == 0) begin
                lat = k; s = sin_o; c = cos_o;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset valid: got %b expected 0", valid_o); end
        checks++; if (sin_o !== 10'd0) begin errors++; $display("FAIL reset sin: got %0d expected 0", sin_o); end
        checks++; if (cos_o !== 10'd0) begin errors++; $display("FAIL reset cos: got %0d expected 0", cos_o); end
        checks++; if (lut_addr_o !== 4'd0) begin errors++; $display("FAIL reset addr: got %0d expected 0", lut_addr_o); end
        rst = 1'b0;
    endtask

    task automatic test_zero_phase();
        logic [3:0] a_s, a_c, bb; int lat; logic [9:0] s, c;
        do_pair(1'b0, 8'h00, 8'h00, 1'b0, a_s, a_c, bb, lat, s, c);
        checks++; if (lat != 4) begin errors++; $display("FAIL zero latency: got %0d expected 4", lat); end
        checks++; if (bb !== 4'b0111) begin errors++; $display("FAIL zero busy: got %b expected 0111", bb); end
        checks++; if (s !== 10'd0) begin errors++; $display("FAIL zero sin: got %0d expected 0", $signed(s)); end
        checks++; if (c !== 10'd256) begin errors++; $display("FAIL zero cos: got %0d expected 256", $signed(c)); end
        checks++; if (a_s !== 4'd0) begin errors++; $display("FAIL zero sin addr: got %0d expected 0", a_s); end
        checks++; if (a_c !== a_s) begin errors++; $display("FAIL zero cos addr held: got %0d expected %0d", a_c, a_s); end
    endtask

    task automatic test_sin_bypass();
        logic [3:0] a_s, a_c, bb; int lat; logic [9:0] s, c;
        do_pair(1'b1, 8'h40, 8'h00, 1'b0, a_s, a_c, bb, lat, s, c);
        checks++; if (s !== 10'd256) begin errors++; $display("FAIL q1 sin: got %0d expected 256", $signed(s)); end
        checks++; if (c !== 10'd0) begin errors++; $display("FAIL q1 cos: got %0d expected 0", $signed(c)); end
        checks++; if (a_c !== 4'd0) begin errors++; $display("FAIL q1 cos addr: got %0d expected 0", a_c); end
    endtask

    task automatic test_diagonal();
        logic [3:0] a_s, a_c, bb; int lat; logic [9:0] s, c;
        do_pair(1'b1, 8'h20, 8'h00, 1'b0, a_s, a_c, bb, lat, s, c);
        checks++; if (s !== 10'd181) begin errors++; $display("FAIL diag sin: got %0d expected 181", $signed(s)); end
        checks++; if (c !== 10'd181) begin errors++; $display("FAIL diag cos: got %0d expected 181", $signed(c)); end
        checks++; if (a_s !== 4'd8) begin errors++; $display("FAIL diag sin addr: got %0d expected 8", a_s); end
        checks++; if (a_c !== 4'd8) begin errors++; $display("FAIL diag cos addr: got %0d expected 8", a_c); end
    endtask

    task automatic test_negative();
        logic [3:0] a_s, a_c, bb; int lat; logic [9:0] s, c;
        do_pair(1'b1, 8'hC4, 8'h00, 1'b0, a_s, a_c, bb, lat, s, c);
        checks++; if (s !== 10'h302) begin errors++; $display("FAIL q3 sin: got %0d expected -254", $signed(s)); end
        checks++; if (c !== 10'd25) begin errors++; $display("FAIL q3 cos: got %0d expected 25", $signed(c)); end
        checks++; if (a_s !== 4'd15) begin errors++; $display("FAIL q3 sin addr: got %0d expected 15", a_s); end
        checks++; if (a_c !== 4'd1) begin errors++; $display("FAIL q3 cos addr: got %0d expected 1", a_c); end
    endtask

    task automatic test_wrap();
        logic [3:0] a_s, a_c, bb; int lat; logic [9:0] s, c;
        do_pair(1'b1, 8'hF0, 8'h20, 1'b1, a_s, a_c, bb, lat, s, c);
        checks++; if (s !== 10'h39F) begin errors++; $display("FAIL wrap1 sin: got %0d expected -97", $signed(s)); end
        checks++; if (c !== 10'd236) begin errors++; $display("FAIL wrap1 cos: got %0d expected 236", $signed(c)); end
        checks++; if (a_s !== 4'd4) begin errors++; $display("FAIL wrap1 sin addr: got %0d expected 4", a_s); end
        checks++; if (a_c !== 4'd12) begin errors++; $display("FAIL wrap1 cos addr: got %0d expected 12", a_c); end
        do_pair(1'b0, 8'h00, 8'h00, 1'b0, a_s, a_c, bb, lat, s, c);
        checks++; if (s !== 10'd97) begin errors++; $display("FAIL wrap2 sin: got %0d expected 97", $signed(s)); end
        checks++; if (c !== 10'd236) begin errors++; $display("FAIL wrap2 cos: got %0d expected 236", $signed(c)); end
        checks++; if (lat != 4) begin errors++; $display("FAIL wrap2 latency: got %0d expected 4", lat); end
    endtask

    task automatic test_back_to_back();
        int nv = 0, p1 = 0, p2 = 0;
        logic [9:0] s2 = '0;
        @(negedge clk);
        start_i = 1'b1; phase_load_i = 1'b1; phase_i = 8'h20; phase_inc_i = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) phase_load_i = 1'b0;
            if (k == 8) start_i = 1'b0;
            if (valid_o) begin
                nv++;
                if (nv == 1) p1 = k;
                if (nv == 2) begin p2 = k; s2 = sin_o; end
            end
        end
        checks++; if (nv != 2) begin errors++; $display("FAIL b2b valid count: got %0d expected 2", nv); end
        checks++; if (p1 != 4) begin errors++; $display("FAIL b2b first valid: got %0d expected 4", p1); end
        checks++; if (p2 != 8) begin errors++; $display("FAIL b2b second valid: got %0d expected 8", p2); end
        checks++; if (s2 !== 10'd181) begin errors++; $display("FAIL b2b sin: got %0d expected 181", $signed(s2)); end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        @(negedge clk);
        start_i = 1'b1; phase_load_i = 1'b1; phase_i = 8'h04; phase_inc_i = 8'h00;
        @(negedge clk);
        start_i = 1'b0; phase_load_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b expected 0", busy_o); end
        checks++; if (sin_o !== 10'd0) begin errors++; $display("FAIL midrst sin: got %0d expected 0", $signed(sin_o)); end
        checks++; if (cos_o !== 10'd0) begin errors++; $display("FAIL midrst cos: got %0d expected 0", $signed(cos_o)); end
        checks++; if (lut_addr_o !== 4'd0) begin errors++; $display("FAIL midrst addr: got %0d expected 0", lut_addr_o); end
        if (valid_o) nv++;
        repeat (6) begin
            @(negedge clk);
            if (valid_o) nv++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL midrst valid count: got %0d expected 0", nv); end
    endtask

    initial begin
        rom[0]  = 9'd0;   rom[1]  = 9'd25;  rom[2]  = 9'd49;  rom[3]  = 9'd74;
        rom[4]  = 9'd97;  rom[5]  = 9'd120; rom[6]  = 9'd142; rom[7]  = 9'd162;
        rom[8]  = 9'd181; rom[9]  = 9'd197; rom[10] = 9'd212; rom[11] = 9'd225;
        rom[12] = 9'd236; rom[13] = 9'd244; rom[14] = 9'd251; rom[15] = 9'd254;
        rst = 1'b1; start_i = 1'b0; phase_load_i = 1'b0; phase_i = '0; phase_inc_i = '0;
        test_reset();
        test_zero_phase();
        test_sin_bypass();
        test_diagonal();
        test_negative();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
